// File: rtl/mem_access_ctrl_if.sv
// Datapath/memory-side bundle for mem_access_ctrl: request/response handshake
// plus the strobes and buses to the 16-bit data memory.
interface mem_access_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              ReqValid;
    logic              ReqWrite;
    logic [ADDR_W-1:0] ReqAddr;
    logic [DATA_W-1:0] ReqData;
    logic              ReqReady;
    logic              RspValid;
    logic [DATA_W-1:0] RspData;
    logic              MisalignErr;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic              MemRead;
    logic              MemWrite;
    logic [DATA_W-1:0] MemRData;

    // slave: the controller; master: datapath plus memory around it
    modport slave (
        input  ReqValid, ReqWrite, ReqAddr, ReqData, MemRData,
        output ReqReady, RspValid, RspData, MisalignErr,
        output MemAddr, MemWData, MemRead, MemWrite
    );
    modport master (
        output ReqValid, ReqWrite, ReqAddr, ReqData, MemRData,
        input  ReqReady, RspValid, RspData, MisalignErr,
        input  MemAddr, MemWData, MemRead, MemWrite
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Multi-cycle load/store sequencer in front of the 16-bit data memory:
// one request at a time, fixed strobe lengths, one-cycle response pulse.
module mem_access_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1,
    parameter int WR_CYC = 1
) (
    input logic             CLK,
    input logic             Reset,
    mem_access_ctrl_if.slave bus
);

    typedef enum logic [2:0] {IDLE, READ, WRITE, ERR, DONE} state_e;

    localparam logic [3:0] RD_INIT = 4'(RD_LAT - 1);
    localparam logic [3:0] WR_INIT = 4'(WR_CYC - 1);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              misalign_q, misalign_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            misalign_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            rsp_valid_q <= rsp_valid_d;
            misalign_q  <= misalign_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Strobes and response flags default low; each state re-asserts what it needs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        rsp_valid_d = 1'b0;
        misalign_d  = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (bus.ReqValid) begin
                    // Odd address: answer immediately, leave the memory bus untouched
                    if (bus.ReqAddr[0]) begin
                        state_d     = ERR;
                        rsp_valid_d = 1'b1;
                        misalign_d  = 1'b1;
                    end else if (bus.ReqWrite) begin
                        state_d     = WRITE;
                        mem_write_d = 1'b1;
                        mem_addr_d  = bus.ReqAddr;
                        mem_wdata_d = bus.ReqData;
                        cnt_d       = WR_INIT;
                    end else begin
                        state_d     = READ;
                        mem_read_d  = 1'b1;
                        mem_addr_d  = bus.ReqAddr;
                        cnt_d       = RD_INIT;
                    end
                end
            end
            READ: begin
                if (cnt_q == 4'd0) begin
                    state_d     = DONE;
                    rsp_data_d  = bus.MemRData;
                    rsp_valid_d = 1'b1;
                end else begin
                    mem_read_d = 1'b1;
                    cnt_d      = cnt_q - 4'd1;
                end
            end
            WRITE: begin
                if (cnt_q == 4'd0) begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                end else begin
                    mem_write_d = 1'b1;
                    cnt_d       = cnt_q - 4'd1;
                end
            end
            ERR:     state_d = IDLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.ReqReady    = (state_q == IDLE);
    assign bus.RspValid    = rsp_valid_q;
    assign bus.RspData     = rsp_data_q;
    assign bus.MisalignErr = misalign_q;
    assign bus.MemAddr     = mem_addr_q;
    assign bus.MemWData    = mem_wdata_q;
    assign bus.MemRead     = mem_read_q;
    assign bus.MemWrite    = mem_write_q;

endmodule
